// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the word width, the fetch FSM states and the FIFO entry layout.
package inst_fetch_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of the fetch stage's memory bus, redirect input and ID-stage handshake.
// The master side is the fetch stage; the slave side is its environment (memory + ID).
interface inst_fetch_if;

    logic                           mem_req;
    logic [inst_fetch_pkg::XLEN-1:0] mem_addr;
    logic                           mem_gnt;
    logic                           mem_rvalid;
    logic [inst_fetch_pkg::XLEN-1:0] mem_rdata;
    logic                           redirect_valid;
    logic [inst_fetch_pkg::XLEN-1:0] redirect_pc;
    logic                           id_valid;
    logic                           id_ready;
    logic [inst_fetch_pkg::XLEN-1:0] id_inst;
    logic [inst_fetch_pkg::XLEN-1:0] id_pc;

    modport master (
        output mem_req, mem_addr, id_valid, id_inst, id_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  mem_req, mem_addr, id_valid, id_inst, id_pc,
        output mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Registered FIFO of {pc, inst} words between the memory response and the ID stage.
// Flush has priority over push/pop; push while full is accepted only with a concurrent pop.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s, full_s;

    // Next-state of storage, pointers and occupancy.
    always_comb begin
        full_s    = (count_q == DEPTH_C);
        do_pop_s  = pop && (count_q != {CW{1'b0}});
        do_push_s = push && (!full_s || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == {CW{1'b0}});

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order word reads, buffers returned words
// and hands {inst, pc} to ID. Redirects flush the buffer and drain stale in-flight reads.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] IDLE_INST = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_SUM = (CW+1)'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [XLEN-1:0] pcq_q [DEPTH];
    logic [XLEN-1:0] pcq_d [DEPTH];
    logic [PW-1:0]   pcq_wr_q, pcq_wr_d;
    logic [PW-1:0]   pcq_rd_q, pcq_rd_d;

    logic            mem_req_s, hs_s, rv_s, push_s, pop_s, id_valid_s, fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    fetch_entry_t    head_s, push_data_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: FLUSH while stale responses are still owed by memory.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.redirect_valid && (outstanding_d != {CW{1'b0}})) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (discard_d == {CW{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM output: request only when the words already owed plus buffered still fit the FIFO.
    always_comb begin
        if (rst && (state_q == ST_RUN) && !bus.redirect_valid &&
            (({1'b0, outstanding_q} + {1'b0, fifo_count_s}) < DEPTH_SUM)) begin
            mem_req_s = 1'b1;
        end else begin
            mem_req_s = 1'b0;
        end
    end

    // Datapath: PC, in-flight/discard counters, request PC queue, FIFO controls.
    always_comb begin
        hs_s          = mem_req_s && bus.mem_gnt;
        rv_s          = bus.mem_rvalid && (outstanding_q != {CW{1'b0}});
        pop_s         = id_valid_s && bus.id_ready;
        push_s        = rv_s && (discard_q == {CW{1'b0}}) && !bus.redirect_valid;
        outstanding_d = outstanding_q + CW'(hs_s) - CW'(rv_s);
        pcq_d         = pcq_q;
        if (hs_s) begin
            pcq_d[pcq_wr_q] = fetch_pc_q;
            pcq_wr_d        = pcq_wr_q + PW'(1);
        end else begin
            pcq_wr_d = pcq_wr_q;
        end
        // Stale entries leave the PC queue as their responses arrive, so no queue flush is needed.
        if (rv_s) begin
            pcq_rd_d = pcq_rd_q + PW'(1);
        end else begin
            pcq_rd_d = pcq_rd_q;
        end
        if (bus.redirect_valid) begin
            fetch_pc_d = word_align(bus.redirect_pc);
            discard_d  = outstanding_d;
        end else begin
            if (hs_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rv_s && (discard_q != {CW{1'b0}})) begin
                discard_d = discard_q - CW'(1);
            end else begin
                discard_d = discard_q;
            end
        end
        push_data_s.pc   = pcq_q[pcq_rd_q];
        push_data_s.inst = bus.mem_rdata;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= {CW{1'b0}};
            discard_q     <= {CW{1'b0}};
            pcq_wr_q      <= {PW{1'b0}};
            pcq_rd_q      <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pcq_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
            pcq_q         <= pcq_d;
        end
    end

    inst_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (bus.redirect_valid),
        .head      (head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

    assign id_valid_s   = !fifo_empty_s;
    assign bus.mem_req  = mem_req_s;
    assign bus.mem_addr = fetch_pc_q;
    assign bus.id_valid = id_valid_s;
    assign bus.id_inst  = id_valid_s ? head_s.inst : IDLE_INST;
    assign bus.id_pc    = id_valid_s ? head_s.pc   : RESET_PC;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch against a queue-based model of in-flight reads and the ID buffer.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if bus1();
    inst_fetch_if bus2();

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2), .IDLE_INST(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .bus(bus1.master)
    );
    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2), .IDLE_INST(32'h0000_0000)) u_dut_wrap (
        .clk(clk), .rst(rst), .bus(bus2.master)
    );

    typedef struct { logic [31:0] pc; bit stale; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } word_t;

    flight_t     inflight[$];
    word_t       fifo_m[$];
    logic [31:0] m_pc;
    logic [31:0] accepted_pc[$];
    logic [31:0] accepted_inst[$];
    logic [31:0] wrap_pcs[$];
    logic        last_valid;
    logic [31:0] last_pc;
    int          checks = 0;
    int          errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not reached within cycle budget", name);
    endtask

    task automatic idle_inputs();
        bus1.mem_gnt = 1'b0; bus1.mem_rvalid = 1'b0; bus1.mem_rdata = 32'h0;
        bus1.id_ready = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = 32'h0;
        bus2.mem_gnt = 1'b0; bus2.mem_rvalid = 1'b0; bus2.mem_rdata = 32'h0;
        bus2.id_ready = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'h0;
    endtask

    // Reset drops all in-flight work; outputs must show reset values at once.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        check1("rst_mem_req", bus1.mem_req, 1'b0);
        check32("rst_mem_addr", bus1.mem_addr, 32'h0000_0000);
        check1("rst_id_valid", bus1.id_valid, 1'b0);
        check32("rst_id_inst", bus1.id_inst, 32'h0000_0000);
        check32("rst_id_pc", bus1.id_pc, 32'h0000_0000);
        check32("rst_wrap_addr", bus2.mem_addr, 32'hFFFF_FFF8);
        check32("rst_wrap_id_pc", bus2.id_pc, 32'hFFFF_FFF8);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        inflight.delete();
        fifo_m.delete();
        m_pc = 32'h0000_0000;
    endtask

    // One cycle: drive, compare DUT to model, then advance the model.
    task automatic step(input bit gnt, input bit rv_en, input bit ready, input bit redir,
                        input logic [31:0] rpc);
        bit          exp_req, exp_valid, flushing, rv, hs;
        logic [31:0] rdata;
        flight_t     f;
        @(negedge clk);
        rv    = rv_en && (inflight.size() > 0);
        rdata = rv ? (inflight[0].pc ^ 32'hA5A5_A5A5) : 32'h0;
        bus1.mem_gnt = gnt; bus1.mem_rvalid = rv; bus1.mem_rdata = rdata;
        bus1.id_ready = ready; bus1.redirect_valid = redir; bus1.redirect_pc = rpc;
        #1;
        flushing = 1'b0;
        foreach (inflight[i]) if (inflight[i].stale) flushing = 1'b1;
        exp_req   = !redir && !flushing && ((inflight.size() + fifo_m.size()) < 2);
        exp_valid = (fifo_m.size() > 0);
        check1("mem_req", bus1.mem_req, exp_req);
        if (exp_req) check32("mem_addr", bus1.mem_addr, m_pc);
        check1("id_valid", bus1.id_valid, exp_valid);
        if (exp_valid) begin
            check32("id_inst", bus1.id_inst, fifo_m[0].inst);
            check32("id_pc", bus1.id_pc, fifo_m[0].pc);
        end else begin
            check32("id_inst_idle", bus1.id_inst, 32'h0000_0000);
        end
        last_valid = bus1.id_valid;
        last_pc    = bus1.id_pc;
        hs = exp_req && gnt;
        if (exp_valid && ready) begin
            accepted_pc.push_back(bus1.id_pc);
            accepted_inst.push_back(bus1.id_inst);
            void'(fifo_m.pop_front());
        end
        if (rv) begin
            f = inflight.pop_front();
            if (!f.stale && !redir) fifo_m.push_back('{f.pc, rdata});
        end
        if (hs) begin
            inflight.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            fifo_m.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
        end
    endtask

    task automatic expect_first_pc(input string name, input logic [31:0] exp_pc);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (last_valid) begin
                check32(name, last_pc, exp_pc);
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now(name);
    endtask

    initial begin
        bit g_prev;
        idle_inputs();
        do_reset();

        // Streaming with immediate grants and responses.
        repeat (30) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        if (accepted_pc.size() < 3) begin
            fail_now("stream_pcs");
        end else begin
            check32("stream_pc0", accepted_pc[0], 32'h0000_0000);
            check32("stream_pc1", accepted_pc[1], 32'h0000_0004);
            check32("stream_pc2", accepted_pc[2], 32'h0000_0008);
            check32("stream_inst0", accepted_inst[0], 32'hA5A5_A5A5);
        end

        // ID stall then release.
        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect with two reads in flight; misaligned target.
        for (int k = 0; k < 20 && inflight.size() != 2; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1003);
        expect_first_pc("redirect_pc", 32'h0000_1000);

        // Redirect coinciding with grant and response.
        for (int k = 0; k < 20 && inflight.size() == 0; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2000);
        expect_first_pc("redirect_same_cycle", 32'h0000_2000);

        // Address wrap through a redirect near the top of memory.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom());
        end

        // Reset with a buffered word and one read in flight.
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 30 && !(fifo_m.size() == 1 && inflight.size() == 1); k++) begin
            step(1'b1, fifo_m.size() == 0, 1'b0, 1'b0, 32'h0);
        end
        if (!(fifo_m.size() == 1 && inflight.size() == 1)) fail_now("reset_setup");
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b1, 1'b0, 32'h0);
        end

        // Wrapping reset PC on the second instance.
        do_reset();
        g_prev = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus2.mem_gnt = 1'b1; bus2.mem_rvalid = g_prev;
            bus2.mem_rdata = 32'h0000_0013; bus2.id_ready = 1'b1;
            #1;
            g_prev = bus2.mem_req;
            if (bus2.id_valid) wrap_pcs.push_back(bus2.id_pc);
        end
        idle_inputs();
        if (wrap_pcs.size() < 3) begin
            fail_now("wrap_pcs");
        end else begin
            check32("wrap_pc0", wrap_pcs[0], 32'hFFFF_FFF8);
            check32("wrap_pc1", wrap_pcs[1], 32'hFFFF_FFFC);
            check32("wrap_pc2", wrap_pcs[2], 32'h0000_0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
